fetch_unit: RTL

- Instruction-fetch initiator for the synchronous-read instruction BRAM, which has one-cycle read latency, no enable and no handshake.
- Owns the PC and drives the word address every cycle.
- Matches each returned word to the PC that requested it.
- Buffers fetched instructions in a small FIFO with a valid/ready handshake toward decode.
- Handles redirects from branch resolution by flushing the in-flight read and the FIFO.

---
 rtl/fetch_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for a one-cycle-latency BRAM, with a small {instr, pc} FIFO toward decode.
// Optional perf counters (perf_fetched, perf_stall) are enabled by defining FETCH_PERF_CNT_EN.
module fetch_unit #(
  parameter int unsigned         ADDR_WIDTH = 9,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter int unsigned         PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         BUF_DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] icache_addr,
  input  logic [DATA_WIDTH-1:0] icache_rdata,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [PC_WIDTH-1:0]   out_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_stall
`endif
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1) + 1;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] instr_q [BUF_DEPTH];
  logic [DATA_WIDTH-1:0] instr_d [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   epc_q [BUF_DEPTH];
  logic [PC_WIDTH-1:0]   epc_d [BUF_DEPTH];
  logic                  pop, push, issue;
  logic [1:0]            unused_rpc_lo;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == BUF_DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  assign unused_rpc_lo = redirect_pc[1:0];
  assign icache_addr   = pc_q[ADDR_WIDTH+1:2];
  assign out_valid     = (occ_q != '0);
  assign out_instr     = instr_q[rd_ptr_q];
  assign out_pc        = epc_q[rd_ptr_q];

  assign pop  = out_valid & out_ready;
  assign push = inflight_q & ~redirect_valid;
  // Credit check counts the in-flight read so a returning word always finds a free slot.
  assign issue = ~redirect_valid &
                 ((occ_q + CNT_W'(inflight_q) - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    occ_d         = occ_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    instr_d       = instr_q;
    epc_d         = epc_q;
    if (redirect_valid) begin
      pc_d     = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      occ_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (issue) begin
        inflight_d    = 1'b1;
        inflight_pc_d = pc_q;
        pc_d          = pc_q + PC_WIDTH'(4);
      end
      if (push) begin
        instr_d[wr_ptr_q] = icache_rdata;
        epc_d[wr_ptr_q]   = inflight_pc_q;
        wr_ptr_d          = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      occ_d = occ_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      occ_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    inflight_pc_q <= inflight_pc_d;
    instr_q       <= instr_d;
    epc_q         <= epc_d;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_q, perf_fetched_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_stall_d   = perf_stall_q;
    if (pop && perf_fetched_q != '1) perf_fetched_d = perf_fetched_q + 32'd1;
    if (out_valid && !out_ready && perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule
